// File: rtl/mac_result_packer.sv
// Quantizes MAC dot-product results (bias, round-half-up shift, saturate) and packs PACK lanes per FIFO word.
// Define MAC_RESULT_PACKER_RELU_EN to clamp negative lanes to zero before saturation.
module mac_result_packer #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ACC_WIDTH-1:0]          in_result,
  input  logic [ACC_WIDTH-1:0]          bias,
  input  logic [4:0]                    shift,
  input  logic                          flush,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [PACK*OUT_WIDTH-1:0]     out_data,
  output logic [$clog2(PACK):0]         out_count,
  input  logic                          out_ready,
  output logic                          overflow
);

  localparam int LW = $clog2(PACK);
  localparam int CW = LW + 1;
  localparam int WW = PACK * OUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = ACC_WIDTH + 2;
  localparam logic signed [SW-1:0] QMAX = SW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] QMIN = SW'(-(2 ** (OUT_WIDTH - 1)));

  // Two guard bits keep bias addition and the rounding increment from wrapping.
  function automatic logic signed [SW-1:0] round_shift(input logic [ACC_WIDTH-1:0] res,
                                                       input logic [ACC_WIDTH-1:0] b,
                                                       input logic [4:0] sh);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] rnd;
    s   = SW'($signed(res)) + SW'($signed(b));
    rnd = '0;
    if (sh != 5'd0) rnd = SW'(1) << (sh - 5'd1);
    round_shift = (s + rnd) >>> sh;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = v;
`ifdef MAC_RESULT_PACKER_RELU_EN
    if (t < 0) t = '0;
`else
`endif
    if (t > QMAX)      saturate = OUT_WIDTH'(QMAX);
    else if (t < QMIN) saturate = OUT_WIDTH'(QMIN);
    else               saturate = OUT_WIDTH'(t);
  endfunction

  // Stage 1: quantize
  logic                 vld_p1_q;
  logic                 flush_p1_q;
  logic [OUT_WIDTH-1:0] lane_p1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q   <= 1'b0;
      flush_p1_q <= 1'b0;
    end else begin
      vld_p1_q   <= in_valid;
      flush_p1_q <= flush;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) lane_p1_q <= saturate(round_shift(in_result, bias, shift));
  end

  // Stage 2: pack; lanes at or above the fill count are masked so stale data never leaks
  logic [LW-1:0] lane_cnt_q, lane_cnt_d;
  logic [WW-1:0] lanes_q;
  logic [WW-1:0] word_d;
  logic [CW-1:0] fill;
  logic [CW-1:0] push_cnt;
  logic          push;

  always_comb begin
    word_d     = '0;
    lane_cnt_d = lane_cnt_q;
    push       = 1'b0;
    push_cnt   = '0;
    fill       = CW'(lane_cnt_q) + CW'(vld_p1_q);
    for (int i = 0; i < PACK; i++) begin
      if (vld_p1_q && LW'(i) == lane_cnt_q)
        word_d[i*OUT_WIDTH +: OUT_WIDTH] = lane_p1_q;
      else if (LW'(i) < lane_cnt_q)
        word_d[i*OUT_WIDTH +: OUT_WIDTH] = lanes_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
    if (fill == CW'(PACK) || (flush_p1_q && fill != '0)) begin
      push       = 1'b1;
      push_cnt   = fill;
      lane_cnt_d = '0;
    end else if (vld_p1_q) begin
      lane_cnt_d = LW'(lane_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lane_cnt_q <= '0;
    else      lane_cnt_q <= lane_cnt_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PACK; i++) begin
      if (vld_p1_q && LW'(i) == lane_cnt_q)
        lanes_q[i*OUT_WIDTH +: OUT_WIDTH] <= lane_p1_q;
    end
  end

  // Output FIFO: a push into a full FIFO succeeds only alongside a pop
  logic [WW-1:0] mem_data [FIFO_DEPTH];
  logic [CW-1:0] mem_cnt  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q;
  logic          overflow_q;
  logic          full, empty, pop, push_ok;

  assign full    = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (occ_q == '0);
  assign pop     = !empty && out_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr_q] <= word_d;
      mem_cnt[wr_ptr_q]  <= push_cnt;
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_data[rd_ptr_q];
  assign out_count = empty ? '0 : mem_cnt[rd_ptr_q];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_result_packer.sv
// Directed, table-driven bench for mac_result_packer; expectations follow the RELU macro when defined.
module tb_mac_result_packer;

`ifdef MAC_RESULT_PACKER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic [31:0] bias;
  logic [4:0]  shift;
  logic        flush;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_ready;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_result_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result), .bias(bias),
    .shift(shift), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_count(out_count), .out_ready(out_ready), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [7:0]  lane;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] r, input logic [31:0] b, input logic [4:0] sh);
    in_valid  = 1'b1;
    in_result = r;
    bias      = b;
    shift     = sh;
    tick();
    in_valid  = 1'b0;
  endtask

  function automatic logic [7:0] exp_lane(input logic [7:0] l);
    return (RELU && l[7]) ? 8'h00 : l;
  endfunction

  initial begin
    logic [31:0] wexp;
    logic [7:0]  nb;

    vecs[0]  = '{32'd1, 32'd0, 5'd0, 8'h01};
    vecs[1]  = '{32'd2, 32'd0, 5'd0, 8'h02};
    vecs[2]  = '{32'd3, 32'd0, 5'd0, 8'h03};
    vecs[3]  = '{32'd4, 32'd0, 5'd0, 8'h04};
    vecs[4]  = '{32'd1000, 32'd0, 5'd0, 8'h7F};
    vecs[5]  = '{32'(-1000), 32'd0, 5'd0, 8'h80};
    vecs[6]  = '{32'd40, 32'd0, 5'd4, 8'h03};
    vecs[7]  = '{32'(-40), 32'd0, 5'd4, 8'hFE};
    vecs[8]  = '{32'd10, 32'd5, 5'd0, 8'h0F};
    vecs[9]  = '{32'(-3), 32'd3, 5'd1, 8'h00};
    vecs[10] = '{32'd7, 32'd0, 5'd1, 8'h04};
    vecs[11] = '{32'(-7), 32'd0, 5'd1, 8'hFD};
    vecs[12] = '{32'(-5), 32'd0, 5'd0, 8'hFB};
    vecs[13] = '{32'd127, 32'd0, 5'd0, 8'h7F};
    vecs[14] = '{32'(-128), 32'd0, 5'd0, 8'h80};
    vecs[15] = '{32'd128, 32'd0, 5'd0, 8'h7F};
    vecs[16] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 8'h7F};
    vecs[17] = '{32'h8000_0000, 32'h8000_0000, 5'd0, 8'h80};
    vecs[18] = '{32'h8000_0000, 32'd0, 5'd31, 8'hFF};
    vecs[19] = '{32'h7FFF_FFFF, 32'd0, 5'd31, 8'h01};

    rst = 1'b0; in_valid = 1'b0; in_result = '0; bias = '0; shift = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_count", 64'(out_count), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    tick();

    for (int w = 0; w < 5; w++) begin
      wexp = '0;
      for (int j = 0; j < 4; j++) begin
        send(vecs[4*w+j].r, vecs[4*w+j].b, vecs[4*w+j].sh);
        wexp[8*j +: 8] = exp_lane(vecs[4*w+j].lane);
      end
      chk($sformatf("w%0d_latency", w), 64'(out_valid), 64'd0);
      tick();
      chk($sformatf("w%0d_valid", w), 64'(out_valid), 64'd1);
      chk($sformatf("w%0d_data", w), 64'(out_data), 64'(wexp));
      chk($sformatf("w%0d_count", w), 64'(out_count), 64'd4);
      chk($sformatf("w%0d_overflow", w), 64'(overflow), 64'd0);
      tick();
      chk($sformatf("w%0d_one_cycle", w), 64'(out_valid), 64'd0);
    end

    // Partial word via flush, then an empty flush
    send(32'd5, 32'd0, 5'd0);
    send(32'd6, 32'd0, 5'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_pending", 64'(out_valid), 64'd0);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd1);
    chk("flush_data", 64'(out_data), 64'h0000_0605);
    chk("flush_count", 64'(out_count), 64'd2);
    tick();
    chk("flush_popped", 64'(out_valid), 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    chk("empty_flush", 64'(out_valid), 64'd0);

    // Flush together with the value that completes a word
    send(32'd1, 32'd0, 5'd0);
    send(32'd2, 32'd0, 5'd0);
    send(32'd3, 32'd0, 5'd0);
    flush = 1'b1; send(32'd4, 32'd0, 5'd0); flush = 1'b0;
    tick();
    chk("flush_full_data", 64'(out_data), 64'h0403_0201);
    chk("flush_full_count", 64'(out_count), 64'd4);
    tick();
    chk("flush_full_single", 64'(out_valid), 64'd0);

    // Flush in the same cycle as a lone input
    flush = 1'b1; send(32'd7, 32'd0, 5'd0); flush = 1'b0;
    tick();
    chk("flush_one_data", 64'(out_data), 64'h0000_0007);
    chk("flush_one_count", 64'(out_count), 64'd1);
    tick();

    // Fill FIFO with out_ready low; fifth word must be dropped
    out_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      for (int j = 0; j < 4; j++) begin
        send(32'(n), 32'd0, 5'd0);
        if (n == 5 && j == 0) begin
          chk("full_in_ready", 64'(in_ready), 64'd0);
          chk("full_no_overflow_yet", 64'(overflow), 64'd0);
        end
      end
    end
    tick();
    chk("ovf_in_ready", 64'(in_ready), 64'd0);
    chk("ovf_set", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      nb = 8'(n);
      chk($sformatf("drain%0d_valid", n), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d_data", n), 64'(out_data), 64'({4{nb}}));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("drain_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset with a partial word pending
    send(32'd1, 32'd0, 5'd0);
    send(32'd2, 32'd0, 5'd0);
    send(32'd3, 32'd0, 5'd0);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    tick(); tick();
    chk("rst_no_partial", 64'(out_valid), 64'd0);
    for (int j = 0; j < 4; j++) send(32'd9, 32'd0, 5'd0);
    tick();
    chk("post_rst_data", 64'(out_data), 64'h0909_0909);
    chk("post_rst_count", 64'(out_count), 64'd4);
    tick();
    chk("post_rst_popped", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
